// File: rtl/x1_pkg.sv
// Shared definitions for the X1 sequencer: opcodes, FSM states,
// instruction field positions and the halt encoding.
package x1_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SRA = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_NUL = 3'b110;
    localparam logic [2:0] OP_LD  = 3'b111;

    localparam int SA_MSB = 15;
    localparam int SA_LSB = 11;
    localparam int DA_MSB = 10;
    localparam int DA_LSB = 6;
    localparam int OP_MSB = 5;
    localparam int OP_LSB = 3;
    localparam int SH_MSB = 2;
    localparam int SH_LSB = 0;
    localparam int DA_W   = DA_MSB - DA_LSB + 1;

    // A NUL opcode with the maximum shift amount is reserved as HALT
    localparam logic [2:0] HALT_OP = OP_NUL;
    localparam logic [2:0] HALT_SH = 3'b111;

    function automatic logic isHalt(input logic [2:0] op, input logic [2:0] sh);
        return (op == HALT_OP) && (sh == HALT_SH);
    endfunction

endpackage

// File: rtl/x1_dec.sv
// Opcode to one-hot operation select for the X1 datapath; the select is
// forced to zero whenever the enable is low.
module x1_dec
    import x1_pkg::*;
(
    input  logic       i_en,
    input  logic [2:0] i_opcode,
    output logic [7:0] o_opSel
);

    // Bit order is {add,sub,mul,srl,sra,sll,nul,ld}, so ADD lands in bit 7
    always_comb begin
        o_opSel = '0;
        if (i_en) begin
            case (i_opcode)
                OP_ADD:  o_opSel = 8'h80;
                OP_SUB:  o_opSel = 8'h40;
                OP_MUL:  o_opSel = 8'h20;
                OP_SRL:  o_opSel = 8'h10;
                OP_SRA:  o_opSel = 8'h08;
                OP_SLL:  o_opSel = 8'h04;
                OP_NUL:  o_opSel = 8'h02;
                default: o_opSel = 8'h01;
            endcase
        end
    end

endmodule

// File: rtl/x1_seq.sv
// X1 sequencer: program loader plus a four-state-per-instruction fetch,
// decode, execute and write-back controller sharing one memory port.
module x1_seq
    import x1_pkg::*;
#(
    parameter int AW = 5,
    parameter int DW = 16,
    parameter int W  = 4
) (
    input  logic          cpuClk,
    input  logic          cpuRst,
    input  logic          start,
    input  logic          wm,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_data,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic [7:0]    op_sel,
    output logic [2:0]    sa,
    output logic          exec_en,
    input  logic [W-1:0]  acc_in,
    output logic          busy,
    output logic          halted,
    output logic [7:0]    retired
);

    state_t          r_state;
    state_t          w_next;
    logic [AW-1:0]   r_pc;
    logic [DA_W-1:0] r_irDa;
    logic [2:0]      r_irOp;
    logic [2:0]      r_irSh;
    logic [7:0]      r_retired;
    logic            w_ldReady;
    logic            w_ldFire;
    logic            w_startGo;
    logic            w_execEn;
    logic            w_fetchedHalt;

    assign w_ldReady     = (r_state == IDLE) || (r_state == HALT);
    // Gating with cpuRst keeps the loader from writing while reset is held
    assign w_ldFire      = cpuRst && ld_valid && w_ldReady;
    assign w_startGo     = w_ldReady && start && !w_ldFire;
    assign w_fetchedHalt = isHalt(mem_rdata[OP_MSB:OP_LSB], mem_rdata[SH_MSB:SH_LSB]);

    always_ff @(posedge cpuClk or negedge cpuRst) begin
        if (!cpuRst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_execEn  = 1'b0;
        ld_ready  = w_ldReady;
        busy      = 1'b0;
        halted    = 1'b0;
        sa        = '0;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (r_state)
            IDLE: begin
                if (w_startGo) w_next = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                mem_addr = r_pc;
                w_next   = DECODE;
            end
            DECODE: begin
                busy     = 1'b1;
                mem_addr = AW'(mem_rdata[SA_MSB:SA_LSB]);
                w_next   = w_fetchedHalt ? HALT : EXEC;
            end
            EXEC: begin
                busy     = 1'b1;
                w_execEn = 1'b1;
                sa       = r_irSh;
                w_next   = WB;
            end
            WB: begin
                busy   = 1'b1;
                w_next = FETCH;
                if (wm) begin
                    mem_we    = 1'b1;
                    mem_addr  = AW'(r_irDa);
                    mem_wdata = DW'(acc_in);
                end
            end
            HALT: begin
                halted = 1'b1;
                if (w_startGo) w_next = FETCH;
            end
            default: w_next = IDLE;
        endcase
        if (w_ldFire) begin
            mem_we    = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
        end
    end

    always_ff @(posedge cpuClk or negedge cpuRst) begin
        if (!cpuRst) begin
            r_pc      <= '0;
            r_irDa    <= '0;
            r_irOp    <= '0;
            r_irSh    <= '0;
            r_retired <= '0;
        end else begin
            case (r_state)
                IDLE, HALT: begin
                    if (w_startGo) begin
                        r_pc      <= '0;
                        r_retired <= '0;
                    end
                end
                DECODE: begin
                    r_irDa <= mem_rdata[DA_MSB:DA_LSB];
                    r_irOp <= mem_rdata[OP_MSB:OP_LSB];
                    r_irSh <= mem_rdata[SH_MSB:SH_LSB];
                    if (w_fetchedHalt) r_retired <= r_retired + 8'd1;
                end
                WB: begin
                    r_pc      <= r_pc + AW'(1);
                    r_retired <= r_retired + 8'd1;
                end
                default: ;
            endcase
        end
    end

    x1_dec u_dec (
        .i_en     (w_execEn),
        .i_opcode (r_irOp),
        .o_opSel  (op_sel)
    );

    assign exec_en = w_execEn;
    assign retired = r_retired;

endmodule

// File: tb/tb_x1_seq.sv
// Directed self-checking bench for x1_seq with a small synchronous-read
// memory attached to the shared port.
module tb_x1_seq;

    logic        cpuClk;
    logic        cpuRst;
    logic        start;
    logic        wm;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_addr;
    logic [15:0] ld_data;
    logic [4:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic [7:0]  op_sel;
    logic [2:0]  sa;
    logic        exec_en;
    logic [3:0]  acc_in;
    logic        busy;
    logic        halted;
    logic [7:0]  retired;

    int testsRun    = 0;
    int testsFailed = 0;

    logic [15:0] mem [0:31];

    x1_seq #(.AW(5), .DW(16), .W(4)) dut (
        .cpuClk    (cpuClk),
        .cpuRst    (cpuRst),
        .start     (start),
        .wm        (wm),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .op_sel    (op_sel),
        .sa        (sa),
        .exec_en   (exec_en),
        .acc_in    (acc_in),
        .busy      (busy),
        .halted    (halted),
        .retired   (retired)
    );

    initial cpuClk = 1'b0;
    always #5 cpuClk = ~cpuClk;

    // Memory with one-cycle read latency, read-before-write on the same address
    always @(posedge cpuClk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge cpuClk);
        #2;
    endtask

    task automatic applyStimulus(input logic iStart, input logic iWm, input logic iLdValid,
                                 input logic [4:0] iLdAddr, input logic [15:0] iLdData,
                                 input logic [3:0] iAcc);
        start    = iStart;
        wm       = iWm;
        ld_valid = iLdValid;
        ld_addr  = iLdAddr;
        ld_data  = iLdData;
        acc_in   = iAcc;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int waitCnt;
        int execCount;

        cpuRst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        cpuRst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd3, 16'hFFFF, 4'h0);
        checkOutput("rstLdReady", 32'(ld_ready), 1);
        checkOutput("rstMemWe", 32'(mem_we), 0);
        checkOutput("rstMemAddr", 32'(mem_addr), 0);
        checkOutput("rstBusy", 32'(busy), 0);
        checkOutput("rstHalted", 32'(halted), 0);
        checkOutput("rstRetired", 32'(retired), 0);
        checkOutput("rstExecEn", 32'(exec_en), 0);
        checkOutput("rstOpSel", 32'(op_sel), 0);
        tick();
        tick();

        cpuRst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd0, 16'h2A78, 4'h0);
        checkOutput("load0We", 32'(mem_we), 1);
        checkOutput("load0Addr", 32'(mem_addr), 0);
        checkOutput("load0Data", 32'(mem_wdata), 32'h2A78);
        tick();
        checkOutput("loadStartStaysIdleBusy", 32'(busy), 0);
        checkOutput("loadStartStaysIdleReady", 32'(ld_ready), 1);
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd1, 16'h3003, 4'h0);
        checkOutput("load1We", 32'(mem_we), 1);
        checkOutput("load1Addr", 32'(mem_addr), 1);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 5'd2, 16'h01B7, 4'h0);
        checkOutput("load2We", 32'(mem_we), 1);
        checkOutput("load2Data", 32'(mem_wdata), 32'h01B7);
        tick();

        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        checkOutput("startCycleWe", 32'(mem_we), 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        checkOutput("fetch0Busy", 32'(busy), 1);
        checkOutput("fetch0Ready", 32'(ld_ready), 0);
        checkOutput("fetch0Addr", 32'(mem_addr), 0);
        checkOutput("fetch0ExecEn", 32'(exec_en), 0);
        tick();
        checkOutput("decode0OperandAddr", 32'(mem_addr), 5);
        checkOutput("decode0OpSel", 32'(op_sel), 0);
        tick();
        checkOutput("exec0ExecEn", 32'(exec_en), 1);
        checkOutput("exec0OpSelLd", 32'(op_sel), 32'h01);
        checkOutput("exec0Sa", 32'(sa), 0);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 16'h0000, 4'hA);
        tick();
        checkOutput("wb0We", 32'(mem_we), 1);
        checkOutput("wb0Addr", 32'(mem_addr), 9);
        checkOutput("wb0Data", 32'(mem_wdata), 32'h000A);
        checkOutput("wb0ExecEn", 32'(exec_en), 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        tick();
        checkOutput("fetch1Addr", 32'(mem_addr), 1);
        checkOutput("fetch1Retired", 32'(retired), 1);
        tick();
        checkOutput("decode1OperandAddr", 32'(mem_addr), 6);
        tick();
        checkOutput("exec1OpSelAdd", 32'(op_sel), 32'h80);
        checkOutput("exec1Sa", 32'(sa), 3);
        tick();
        checkOutput("wb1NoWriteWithoutWm", 32'(mem_we), 0);
        tick();
        checkOutput("fetch2Addr", 32'(mem_addr), 2);
        checkOutput("fetch2Retired", 32'(retired), 2);
        tick();
        checkOutput("decodeHaltExecEn", 32'(exec_en), 0);
        tick();
        checkOutput("haltHalted", 32'(halted), 1);
        checkOutput("haltBusy", 32'(busy), 0);
        checkOutput("haltReady", 32'(ld_ready), 1);
        checkOutput("haltRetired", 32'(retired), 3);
        checkOutput("haltExecEn", 32'(exec_en), 0);
        tick();
        checkOutput("haltHolds", 32'(halted), 1);

        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        checkOutput("restartRetiredCleared", 32'(retired), 0);
        checkOutput("restartFetchAddr", 32'(mem_addr), 0);
        tick();
        tick();
        checkOutput("preResetExecEn", 32'(exec_en), 1);
        applyStimulus(1'b0, 1'b1, 1'b0, 5'd0, 16'h0000, 4'hF);
        cpuRst = 1'b0;
        #1;
        checkOutput("midExecRstExecEn", 32'(exec_en), 0);
        checkOutput("midExecRstMemWe", 32'(mem_we), 0);
        checkOutput("midExecRstReady", 32'(ld_ready), 1);
        checkOutput("midExecRstBusy", 32'(busy), 0);
        checkOutput("midExecRstOpSel", 32'(op_sel), 0);
        tick();
        checkOutput("heldRstMemWe", 32'(mem_we), 0);
        cpuRst = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        checkOutput("firstEdgeAfterRstBusy", 32'(busy), 1);
        checkOutput("firstEdgeAfterRstAddr", 32'(mem_addr), 0);

        waitCnt = 0;
        while (!halted && waitCnt < 40) begin
            tick();
            waitCnt++;
        end
        checkOutput("reachedHaltAgain", 32'(halted), 1);

        for (int i = 0; i < 32; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 5'(i), 16'h07C0, 4'h0);
            tick();
        end
        checkOutput("loadInHaltStaysHalted", 32'(halted), 1);

        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 5'd0, 16'h0000, 4'h0);
        execCount = 0;
        for (int c = 1; c <= 128; c++) begin
            if (c == 125) checkOutput("fetchAddr31", 32'(mem_addr), 31);
            if (exec_en) execCount++;
            tick();
        end
        checkOutput("wrapFetchAddr", 32'(mem_addr), 0);
        checkOutput("wrapBusy", 32'(busy), 1);
        checkOutput("wrapRetired", 32'(retired), 32);
        checkOutput("wrapExecCount", 32'(execCount), 32);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/x1_seq.md
X1_SEQ -- requirements
Module: x1_seq

Interface
REQ-001 Parameter AW, default 5, memory address width (32 words).
REQ-002 Parameter DW, default 16, memory word width.
REQ-003 Parameter W, default 4, accumulator/operand width.
REQ-004 cpuClk  in  1  sole clock; all state changes on rising edge.
REQ-005 cpuRst  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  begin program execution from address 0; sampled in IDLE only.
REQ-007 wm  in  1  write-back enable; sampled in WB.
REQ-008 ld_valid/ld_ready  in/out  1/1  program-load handshake; transfer when both high on a clock edge.
REQ-009 ld_addr, ld_data  in  AW, DW  program-load word and target address.
REQ-010 mem_addr, mem_we, mem_wdata  out  AW, 1, DW  shared memory port (synchronous read, 1-cycle latency).
REQ-011 mem_rdata  in  DW  read data for the address presented the previous cycle.
REQ-012 op_sel  out  8  one-hot {add,sub,mul,srl,sra,sll,nul,ld} to datapath, valid with exec_en.
REQ-013 sa  out  3  shift amount; exec_en  out  1  one-cycle accumulator update strobe.
REQ-014 acc_in  in  W  datapath accumulator value for write-back.
REQ-015 busy, halted  out  1, 1  status; retired  out  8  instructions-retired count.

Function
REQ-016 FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-017 Instruction fields: SA=[15:11], DA=[10:6], opcode=[5:3], sa=[2:0].
REQ-018 IDLE: ld_ready=1; start=1 with no load transfer -> FETCH, PC<=0, retired<=0.
REQ-019 IDLE with ld_valid=1 and start=1 same cycle: load wins, start ignored, state stays IDLE.
REQ-020 Load transfer: mem_we=1, mem_addr=ld_addr, mem_wdata=ld_data in that cycle; one word per cycle, no stall.
REQ-021 ld_ready=0 in FETCH, DECODE, EXEC, WB; ld_ready=1 in IDLE and HALT.
REQ-022 FETCH: mem_addr=PC, mem_we=0 -> DECODE.
REQ-023 DECODE: IR<=mem_rdata; mem_addr=mem_rdata[15:11] (operand read) -> EXEC.
REQ-024 DECODE halt rule: opcode=110 and sa=111 -> HALT, no exec_en, retired incremented.
REQ-025 EXEC: exec_en=1 exactly one cycle; op_sel=onehot(IR opcode), sa=IR[2:0]; datapath uses mem_rdata[W-1:0] as operand -> WB.
REQ-026 op_sel=0 and exec_en=0 in every state other than EXEC.
REQ-027 WB: if wm=1, mem_we=1, mem_addr=DA, mem_wdata=zero-extended acc_in; PC<=PC+1 mod 2^AW; retired<=retired+1 mod 256 -> FETCH.
REQ-028 Throughput: exactly 4 cycles per non-halt instruction; start-to-first-exec_en = 3 cycles.
REQ-029 PC wrap: PC=31 retires to PC=0, execution continues.
REQ-030 HALT: halted=1, busy=0, ld_ready=1; start=1 (no load same cycle) -> FETCH, PC<=0, retired<=0.
REQ-031 busy=1 in FETCH, DECODE, EXEC, WB, else 0.
REQ-032 Write-back to the address of the next instruction is visible on the following FETCH (no forwarding needed; port is single).

Reset
REQ-033 cpuRst low asynchronously forces IDLE, PC=0, IR=0, retired=0, all outputs 0 except ld_ready=1.
REQ-034 Reset mid-instruction aborts it; no mem_we or exec_en asserts while cpuRst low.
REQ-035 First state change after reset release occurs on the first rising edge with cpuRst high.

Structure
REQ-036 Shared package x1_pkg holds opcode constants (ADD=000 ... LD=111), state enum, field bit positions, HALT encoding.
REQ-037 One sub-module x1_dec: combinational opcode-to-one-hot op_sel decoder, shared with the datapath.
REQ-038 Memory port mux (loader vs WB) is local logic in x1_seq, not a sub-module.

Verification
REQ-039 Reset mid-EXEC: assert cpuRst low during EXEC -> IDLE, exec_en=0, mem_we=0, ld_ready=1 immediately.
REQ-040 Load 3 words (addr 0..2) then start -> mem_we high 3 cycles with matching addr/data; first exec_en 3 cycles after start.
REQ-041 Program {LD from 5, ADD from 6, HALT 0x01B7... opcode110 sa111} -> op_sel 0x01 then 0x80, halted=1, retired=3.
REQ-042 wm=1, instruction DA=9, acc_in=0xA -> WB cycle mem_we=1, mem_addr=9, mem_wdata=0x000A.
REQ-043 ld_valid and start both high in IDLE -> word written, state remains IDLE, busy=0.
REQ-044 32 non-halt instructions from PC=0 -> PC wraps to 0, retired=32, fetch address 0 on cycle 129.
